// File: rtl/adc_sample_scheduler.sv
// Sequences the shared SPI front-end: one pre-amp gain write after reset, then periodic
// ADC conversions whose truncated 8-bit result is published with a 1-cycle valid strobe.
module adc_sample_scheduler #(
   parameter int unsigned SAMPLE_DIV  = 5000,
   parameter logic [7:0]  AMP_GAIN    = 8'h11,
   parameter int unsigned SPI_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        spi_busy,
   input  logic        spi_done,
   input  logic [13:0] adc_data,
   output logic        amp_req,
   output logic [7:0]  amp_gain,
   output logic        conv_req,
   output logic [7:0]  sample_out,
   output logic        sample_valid,
   output logic        overrun,
   output logic        timeout_err
);

   localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
   localparam int unsigned WAIT_W = $clog2(SPI_TIMEOUT + 1);

   typedef enum logic [2:0] {
      AMP_CFG,
      AMP_WAIT,
      IDLE,
      CONV_PEND,
      CONV_WAIT,
      PUBLISH
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DIV_W-1:0]    div_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                run;
   logic                tick;
   logic                waiting;
   logic                expired;
   logic                amp_fire;
   logic                conv_fire;
   logic                latch_sample;
   logic                set_overrun;

   assign amp_gain     = AMP_GAIN;
   assign sample_valid = (state == PUBLISH);

   assign run     = enable & ~timeout_err;
   assign tick    = run && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign waiting = (state == AMP_WAIT) || (state == CONV_WAIT);
   // A done arriving in the last allowed cycle still wins over the timeout.
   assign expired = waiting && !spi_done && (wait_cnt == WAIT_W'(SPI_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (!run || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= AMP_CFG;
         amp_req     <= 1'b0;
         conv_req    <= 1'b0;
         wait_cnt    <= '0;
         sample_out  <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state    <= state_next;
         amp_req  <= amp_fire;
         conv_req <= conv_fire;
         if (amp_fire || conv_fire) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (latch_sample) begin
            sample_out <= adc_data[13:6];
         end
         if (set_overrun) begin
            overrun <= 1'b1;
         end
         if (expired) begin
            timeout_err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         AMP_CFG: begin
            if (!spi_busy && !timeout_err) state_next = AMP_WAIT;
         end
         AMP_WAIT: begin
            if (spi_done || expired) state_next = IDLE;
         end
         IDLE: begin
            if (tick) state_next = spi_busy ? CONV_PEND : CONV_WAIT;
         end
         CONV_PEND: begin
            if (!spi_busy && !timeout_err) state_next = CONV_WAIT;
         end
         CONV_WAIT: begin
            if (spi_done)     state_next = PUBLISH;
            else if (expired) state_next = IDLE;
         end
         PUBLISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = AMP_CFG;
         end
      endcase
   end

   // Request pulses are registered, so they follow the deciding cycle by one clock.
   always_comb begin
      amp_fire     = (state == AMP_CFG) && (state_next == AMP_WAIT);
      conv_fire    = (state != CONV_WAIT) && (state_next == CONV_WAIT);
      latch_sample = (state == CONV_WAIT) && spi_done;
      set_overrun  = tick && ((state == CONV_PEND) || (state == CONV_WAIT) ||
                              (state == PUBLISH));
   end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: behavioural SPI responder, sample scoreboard,
// table-driven conversions, directed corner sequences and a randomized tick/overrun model.
`timescale 1ns/1ps
module tb_adc_sample_scheduler;

   localparam int         DIV  = 100;
   localparam int         TMO  = 255;
   localparam logic [7:0] GAIN = 8'h11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        spi_busy = 1'b0;
   logic        spi_done = 1'b0;
   logic [13:0] adc_data = '0;
   logic        amp_req, conv_req, sample_valid, overrun, timeout_err;
   logic [7:0]  amp_gain, sample_out;

   adc_sample_scheduler #(
      .SAMPLE_DIV (DIV),
      .AMP_GAIN   (GAIN),
      .SPI_TIMEOUT(TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .spi_busy    (spi_busy),
      .spi_done    (spi_done),
      .adc_data    (adc_data),
      .amp_req     (amp_req),
      .amp_gain    (amp_gain),
      .conv_req    (conv_req),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_pass = 0;
   int n_total = 0;
   int ncyc = 0;

   // SPI responder: answers each request tx_delay cycles later (0 = never answers)
   int          tx_delay = 30;
   logic [13:0] tx_data = '0;
   bit          tx_active = 0;
   bit          tx_never = 0;
   bit          tx_conv = 0;
   int          tx_left = 0;
   logic [13:0] tx_cur = '0;
   bit          force_busy = 0;
   logic [7:0]  exp_q[$];
   int          last_done = -10;
   int          n_amp = 0, n_conv = 0, n_valid = 0;

   // randomized-phase reference: ticks every DIV cycles from enable; busy window per conversion
   bit rm_on = 0;
   int rm_c = 0, rm_exp_req = -1, rm_busy_end = -1, rm_n = 0;
   bit rm_ovr = 0, rm_tick_prev = 0;

   typedef struct {
      logic [13:0] adc;
      int          delay;
      logic [7:0]  exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, ncyc);
   endtask

   task automatic set_busy(input bit b);
      force_busy = b;
      spi_busy   = tx_active | spi_done | b;
   endtask

   task automatic cyc();
      bit busy_before;
      int d;
      @(posedge clk);
      #1;
      ncyc++;
      busy_before = spi_busy;
      if (amp_req || conv_req) begin
         chk("req_exclusive", amp_req & conv_req, 0);
         chk("req_while_busy", busy_before, 0);
      end
      if (amp_req) n_amp++;
      if (conv_req) n_conv++;
      if (sample_valid) begin
         n_valid++;
         chk("valid_after_done", ncyc, last_done + 1);
         if (exp_q.size() == 0) chk("valid_without_conversion", sample_valid, 0);
         else chk("sample_scoreboard", sample_out, exp_q.pop_front());
      end
      spi_done = 1'b0;
      if (tx_active && !tx_never) begin
         tx_left--;
         if (tx_left == 0) begin
            spi_done  = 1'b1;
            adc_data  = tx_cur;
            tx_active = 0;
            last_done = ncyc;
            if (tx_conv) exp_q.push_back(tx_cur[13:6]);
         end
      end
      if (amp_req || conv_req) begin
         tx_active = 1;
         tx_conv   = conv_req;
         tx_left   = tx_delay;
         tx_never  = (tx_delay == 0);
         tx_cur    = tx_data;
      end
      spi_busy = tx_active | spi_done | force_busy;
      if (rm_on) begin
         if (rm_tick_prev) chk("overrun_rand", overrun, rm_ovr);
         if (conv_req || ncyc == rm_exp_req) chk("conv_req_rand", conv_req, ncyc == rm_exp_req);
         rm_tick_prev = 0;
         if ((ncyc - rm_c) >= DIV - 1 && ((ncyc - rm_c - (DIV - 1)) % DIV) == 0) begin
            rm_tick_prev = 1;
            if (ncyc <= rm_busy_end) begin
               rm_ovr = 1;
            end else begin
               d = ($urandom_range(4, 0) == 0) ? int'($urandom_range(240, 110))
                                                : int'($urandom_range(90, 3));
               tx_delay    = d;
               tx_data     = 14'($urandom);
               rm_exp_req  = ncyc + 1;
               rm_busy_end = ncyc + 1 + d + 1;
               rm_n++;
            end
         end
      end
   endtask

   // which: 0 = amp_req, 1 = conv_req, 2 = sample_valid
   task automatic wait_sig(input int which, input int budget, input string name, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if ((which == 0 && amp_req) || (which == 1 && conv_req) || (which == 2 && sample_valid)) begin
            at = ncyc;
            break;
         end
      end
      if (at < 0) begin
         n_total++;
         $display("FAIL %s: no pulse within %0d cycles (cycle %0d)", name, budget, ncyc);
      end
   endtask

   task automatic bring_up(input int amp_delay);
      int at, a0, rel;
      rst = 1'b0;
      enable = 1'b0;
      rm_on = 0;
      tx_active = 0;
      spi_done = 1'b0;
      set_busy(0);
      exp_q.delete();
      repeat (2) cyc();
      chk("reset_timeout_err", timeout_err, 0);
      chk("reset_overrun", overrun, 0);
      a0 = n_amp;
      rel = ncyc;
      tx_delay = amp_delay;
      rst = 1'b1;
      wait_sig(0, 3, "amp_req_after_reset", at);
      chk("amp_req_latency", (at > rel) && (at <= rel + 2), 1);
      chk("amp_gain", amp_gain, GAIN);
      repeat (amp_delay + 4) cyc();
      chk("amp_req_once", n_amp - a0, 1);
   endtask

   initial begin
      vec_t vecs [6];
      int at, v, prev, c, r, r2, x, a2, v0, c0;

      vecs[0] = '{14'h1FC0, 30, 8'h7F};
      vecs[1] = '{14'h2000, 30, 8'h80};
      vecs[2] = '{14'h3FFF, 30, 8'hFF};
      vecs[3] = '{14'h003F, 5,  8'h00};
      vecs[4] = '{14'h1555, 60, 8'h55};
      vecs[5] = '{14'h2AC0, 1,  8'hAB};

      // reset state, then gain write answered after 40 cycles
      cyc();
      chk("rst_amp_req", amp_req, 0);
      chk("rst_conv_req", conv_req, 0);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_sample_out", sample_out, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_amp_gain", amp_gain, 8'h11);
      bring_up(40);
      repeat (50) cyc();
      chk("no_conv_while_disabled", n_conv, 0);

      // periodic conversions with table data
      enable = 1'b1;
      c = ncyc;
      prev = c;
      for (int i = 0; i < 6; i++) begin
         tx_delay = vecs[i].delay;
         tx_data  = vecs[i].adc;
         wait_sig(1, DIV + 5, "conv_req_table", at);
         chk("conv_period", at - prev, DIV);
         prev = at;
         wait_sig(2, vecs[i].delay + 5, "valid_table", v);
         chk("valid_latency", v - at, vecs[i].delay + 1);
         chk("sample_out", sample_out, vecs[i].exp);
         cyc();
         chk("sample_hold", sample_out, vecs[i].exp);
      end
      chk("no_overrun_short_delays", overrun, 0);

      // long SPI delay: second tick lands in CONV_WAIT
      tx_delay = 150;
      tx_data  = 14'h0AC0;
      wait_sig(1, DIV + 5, "conv_req_long", r);
      repeat (r + DIV - 1 - ncyc) cyc();
      chk("overrun_before_2nd_tick", overrun, 0);
      cyc();
      chk("overrun_after_2nd_tick", overrun, 1);
      v0 = n_valid;
      tx_delay = 30;
      tx_data  = 14'h0FC0;
      wait_sig(1, DIV + 5, "conv_after_overrun", a2);
      chk("conv_after_overrun_period", a2 - r, 2 * DIV);
      chk("valid_once_per_conv", n_valid - v0, 1);

      // enable dropped while waiting: sample still publishes, then silence
      repeat (10) cyc();
      enable = 1'b0;
      wait_sig(2, 40, "valid_after_disable", v);
      chk("valid_after_disable_latency", v - a2, 31);
      c0 = n_conv;
      repeat (3 * DIV) cyc();
      chk("no_conv_after_disable", n_conv - c0, 0);

      // tick while SPI busy is held until the bus frees
      tx_delay = 30;
      tx_data  = 14'h0040;
      enable = 1'b1;
      c = ncyc;
      repeat (DIV - 5) cyc();
      set_busy(1);
      repeat (15) cyc();
      set_busy(0);
      x = ncyc;
      wait_sig(1, 5, "conv_after_busy", at);
      chk("pend_release_latency", at - x, 1);
      wait_sig(2, 40, "valid_after_pend", v);
      enable = 1'b0;

      // SPI never answers
      bring_up(20);
      tx_delay = 0;
      enable = 1'b1;
      wait_sig(1, DIV + 5, "conv_before_timeout", r);
      repeat (r + TMO - 1 - ncyc) cyc();
      chk("timeout_before_limit", timeout_err, 0);
      cyc();
      chk("timeout_at_limit", timeout_err, 1);
      c0 = n_conv;
      repeat (3 * DIV) cyc();
      chk("no_conv_after_timeout", n_conv - c0, 0);
      chk("timeout_sticky", timeout_err, 1);
      bring_up(20);
      chk("timeout_cleared_by_reset", timeout_err, 0);

      // async reset in the middle of a conversion
      tx_delay = 150;
      tx_data  = 14'h3FFF;
      enable = 1'b1;
      wait_sig(1, DIV + 5, "conv_pre_async", r);
      tx_delay = 100;
      tx_data  = 14'h1234;
      wait_sig(2, 160, "valid_pre_async", v);
      wait_sig(1, DIV, "conv_pre_async_2", r2);
      chk("async_setup_sample", sample_out, 8'hFF);
      chk("async_setup_overrun", overrun, 1);
      repeat (20) cyc();
      #2;
      rst = 1'b0;
      #1;
      chk("async_amp_req", amp_req, 0);
      chk("async_conv_req", conv_req, 0);
      chk("async_sample_valid", sample_valid, 0);
      chk("async_sample_out", sample_out, 0);
      chk("async_overrun", overrun, 0);
      chk("async_timeout_err", timeout_err, 0);
      bring_up(25);

      // randomized periodic run against the tick/busy-window model
      c0 = n_conv;
      v0 = n_valid;
      enable = 1'b1;
      rm_c = ncyc;
      rm_exp_req = -1;
      rm_busy_end = -1;
      rm_ovr = 0;
      rm_tick_prev = 0;
      rm_n = 0;
      rm_on = 1;
      repeat (25 * DIV) cyc();
      rm_on = 0;
      enable = 1'b0;
      repeat (300) cyc();
      chk("rand_conv_count", n_conv - c0, rm_n);
      chk("rand_valid_count", n_valid - v0, rm_n);
      chk("rand_overrun_final", overrun, rm_ovr);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
